// File: rtl/sprite_reg_writer_pkg.sv
// Shared definitions for the display register writer: register map, FSM states
// and the register word type.
package sprite_regs_pkg;

  localparam int unsigned NUM_REGS = 13;

  localparam int unsigned DINO_X     = 0;
  localparam int unsigned DINO_Y     = 1;
  localparam int unsigned JUMP_X     = 2;
  localparam int unsigned JUMP_Y     = 3;
  localparam int unsigned DUCK_X     = 4;
  localparam int unsigned DUCK_Y     = 5;
  localparam int unsigned S_CAC_X    = 6;
  localparam int unsigned S_CAC_Y    = 7;
  localparam int unsigned GODZILLA_X = 8;
  localparam int unsigned GODZILLA_Y = 9;
  localparam int unsigned SCORE      = 10;
  localparam int unsigned SCORE_X    = 11;
  localparam int unsigned SCORE_Y    = 12;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE
  } state_t;

  typedef logic [31:0] reg_word_t;

endpackage

// File: rtl/sprite_reg_writer_if.sv
// Write-only register bus between the writer (master) and the display
// peripheral (slave).
interface sprite_reg_writer_if;
  import sprite_regs_pkg::*;

  logic      chipselect;
  logic      write;
  logic [8:0] address;
  reg_word_t writedata;
  logic      waitrequest;

  modport master (
    output chipselect,
    output write,
    output address,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  chipselect,
    input  write,
    input  address,
    input  writedata,
    output waitrequest
  );

endinterface

// File: rtl/sprite_reg_writer_pe.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_pe #(
  parameter int unsigned W     = 13,
  parameter int unsigned IDX_W = 4
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  import sprite_regs_pkg::*;

  // Walk downwards so the lowest set bit is the last one to assign.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = W; i > 0; i--) begin
      if (i_vec[i-1]) begin
        o_idx = IDX_W'(i - 1);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_reg_writer.sv
// Shadow register table committed to the display one changed entry per write,
// starting at each vertical-sync falling edge.
module sprite_reg_writer #(
  parameter int unsigned NUM_REGS = 13,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned MISS_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid,
  input  logic [IDX_W-1:0]     upd_index,
  input  logic [31:0]          upd_data,
  input  logic                 vga_vs,
  sprite_reg_writer_if.master  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [MISS_W-1:0]    missed_frames
);
  import sprite_regs_pkg::*;

  state_t              r_state;
  state_t              w_next;
  logic                r_vs_q;
  reg_word_t           r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [NUM_REGS-1:0] r_pending;
  logic [IDX_W-1:0]    r_idx;
  logic [8:0]          r_addr;
  reg_word_t           r_data;
  logic                r_keep;
  logic [MISS_W-1:0]   r_missed;

  logic                w_edge;
  logic                w_upd_ok;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_any;
  logic                w_accept;

  assign w_edge   = r_vs_q & ~vga_vs;
  assign w_upd_ok = upd_valid && (32'(upd_index) < NUM_REGS);
  assign w_accept = (r_state == WRITE) && !bus.waitrequest;

  lowest_set_pe #(
    .W     (NUM_REGS),
    .IDX_W (IDX_W)
  ) u_pe (
    .i_vec (r_pending),
    .o_idx (w_sel_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_edge) w_next = SCAN;
      SCAN:    w_next = w_any ? WRITE : IDLE;
      WRITE:   if (!bus.waitrequest) w_next = SCAN;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = r_addr;
    bus.writedata  = r_data;
    busy           = (r_state != IDLE);
    frame_done     = 1'b0;
    missed_frames  = r_missed;
    case (r_state)
      SCAN:  frame_done = !w_any;
      WRITE: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_upd_ok) begin
      r_shadow[upd_index] <= upd_data;
    end
  end

  // r_keep remembers an update to the in-flight index made after it was
  // latched, so acceptance must not clear its dirty bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dirty <= '0;
    end else begin
      if (w_accept && !r_keep) r_dirty[r_idx] <= 1'b0;
      if (w_upd_ok)            r_dirty[upd_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_keep    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_edge) r_pending <= r_dirty;
        SCAN: if (w_any) begin
          r_pending[w_sel_idx] <= 1'b0;
          r_idx                <= w_sel_idx;
          r_addr               <= 9'(w_sel_idx);
          r_data               <= r_shadow[w_sel_idx];
          r_keep               <= w_upd_ok && (upd_index == w_sel_idx);
        end
        WRITE: if (w_upd_ok && (upd_index == r_idx)) r_keep <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_q   <= 1'b1;
      r_missed <= '0;
    end else begin
      r_vs_q <= vga_vs;
      if (w_edge && (r_state != IDLE) && (r_missed != '1)) begin
        r_missed <= r_missed + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Directed bench for sprite_reg_writer: scoreboard of expected bus writes plus
// cycle-accurate checks of latency, stalls, conflicts, saturation and reset.
module tb_sprite_reg_writer;
  import sprite_regs_pkg::*;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic [31:0] upd_data;
  logic        vga_vs;
  logic        busy;
  logic        frame_done;
  logic [7:0]  missed_frames;

  int errors = 0;
  int checks = 0;
  int n_accept = 0;
  wr_t sb_q[$];

  logic        lg_wr   [16];
  logic [8:0]  lg_addr [16];
  logic [31:0] lg_data [16];
  logic        lg_fd   [16];
  logic        lg_busy [16];

  sprite_reg_writer_if bus_if ();

  sprite_reg_writer #(
    .NUM_REGS (13),
    .IDX_W    (4),
    .MISS_W   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_data      (upd_data),
    .vga_vs        (vga_vs),
    .bus           (bus_if.master),
    .busy          (busy),
    .frame_done    (frame_done),
    .missed_frames (missed_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus_if.write === 1'b1 && bus_if.waitrequest === 1'b0) begin
      wr_t exp_w;
      n_accept++;
      chk("sb_expected_write", 64'(sb_q.size() > 0), 64'd1);
      chk("cs_with_write", 64'(bus_if.chipselect), 64'd1);
      if (sb_q.size() > 0) begin
        exp_w = sb_q.pop_front();
        chk("sb_addr", 64'(bus_if.address), 64'(exp_w.addr));
        chk("sb_data", 64'(bus_if.writedata), 64'(exp_w.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int unsigned idx, input logic [31:0] data);
    upd_valid = 1'b1;
    upd_index = 4'(idx);
    upd_data  = data;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic push_exp(input int unsigned idx, input logic [31:0] data);
    wr_t w;
    w.addr = 9'(idx);
    w.data = data;
    sb_q.push_back(w);
  endtask

  // Falling vsync in cycle 0, then log n cycles of bus activity.
  task automatic frame_log(input int n);
    vga_vs = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      lg_wr[c]   = bus_if.write;
      lg_addr[c] = bus_if.address;
      lg_data[c] = bus_if.writedata;
      lg_fd[c]   = frame_done;
      lg_busy[c] = busy;
      @(posedge clk);
      #1;
      if (c == 0) vga_vs = 1'b1;
    end
  endtask

  task automatic wait_frame_done(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("frame_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    int acc0;
    reset = 1'b1;
    upd_valid = 1'b0;
    upd_index = '0;
    upd_data = '0;
    vga_vs = 1'b1;
    bus_if.waitrequest = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write", 64'(bus_if.write), 64'd0);
    chk("rst_cs", 64'(bus_if.chipselect), 64'd0);
    chk("rst_addr", 64'(bus_if.address), 64'd0);
    chk("rst_data", 64'(bus_if.writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_missed", 64'(missed_frames), 64'd0);
    step();

    // Two dirty entries, no stalls: writes in cycles 2 and 4, done in 5.
    upd(DINO_X, 32'd100);
    upd(SCORE_Y, 32'd441);
    push_exp(DINO_X, 32'd100);
    push_exp(SCORE_Y, 32'd441);
    frame_log(8);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("f1_write_c%0d", c), 64'(lg_wr[c]), 64'(c == 2 || c == 4));
      chk($sformatf("f1_fd_c%0d", c), 64'(lg_fd[c]), 64'(c == 5));
    end
    chk("f1_addr_c2", 64'(lg_addr[2]), 64'd0);
    chk("f1_data_c2", 64'(lg_data[2]), 64'd100);
    chk("f1_addr_c4", 64'(lg_addr[4]), 64'd12);
    chk("f1_data_c4", 64'(lg_data[4]), 64'd441);
    chk("f1_busy_c0", 64'(lg_busy[0]), 64'd0);
    chk("f1_busy_c1", 64'(lg_busy[1]), 64'd1);
    chk("f1_busy_c5", 64'(lg_busy[5]), 64'd1);
    chk("f1_busy_c6", 64'(lg_busy[6]), 64'd0);

    frame_log(4);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("f2_write_c%0d", c), 64'(lg_wr[c]), 64'd0);
    end
    chk("f2_fd_c1", 64'(lg_fd[1]), 64'd1);

    // Stall the first write for 5 cycles.
    acc0 = n_accept;
    upd(DINO_Y, 32'd11);
    upd(DUCK_Y, 32'd55);
    push_exp(DINO_Y, 32'd11);
    push_exp(DUCK_Y, 32'd55);
    bus_if.waitrequest = 1'b1;
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_write_%0d", k), 64'(bus_if.write), 64'd1);
      chk($sformatf("stall_addr_%0d", k), 64'(bus_if.address), 64'd1);
      chk($sformatf("stall_data_%0d", k), 64'(bus_if.writedata), 64'd11);
      step();
    end
    bus_if.waitrequest = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("stall_next_write", 64'(bus_if.write), 64'd1);
    chk("stall_next_addr", 64'(bus_if.address), 64'd5);
    step();
    wait_frame_done(6);
    chk("stall_accepts", 64'(n_accept - acc0), 64'd2);

    // Update idx 3 in its own acceptance cycle.
    upd(JUMP_Y, 32'd50);
    push_exp(JUMP_Y, 32'd50);
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    upd(JUMP_Y, 32'd60);
    wait_frame_done(6);
    push_exp(JUMP_Y, 32'd60);
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    wait_frame_done(8);

    // Update a pending entry and an already-sent entry mid-flush.
    upd(JUMP_X, 32'd20);
    upd(GODZILLA_Y, 32'd90);
    push_exp(JUMP_X, 32'd20);
    push_exp(GODZILLA_Y, 32'd77);
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    upd(GODZILLA_Y, 32'd77);
    upd(JUMP_X, 32'd22);
    wait_frame_done(6);
    push_exp(JUMP_X, 32'd22);
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    wait_frame_done(8);
    chk("conflict_sb_empty", 64'(sb_q.size()), 64'd0);

    // 300 sync edges while stalled: counter saturates, flush not restarted.
    upd(DUCK_X, 32'd44);
    push_exp(DUCK_X, 32'd44);
    bus_if.waitrequest = 1'b1;
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    @(negedge clk);
    chk("missed_before", 64'(missed_frames), 64'd0);
    step();
    for (int e = 0; e < 300; e++) begin
      vga_vs = 1'b0;
      step();
      vga_vs = 1'b1;
      step();
    end
    @(negedge clk);
    chk("missed_sat", 64'(missed_frames), 64'd255);
    chk("missed_still_write", 64'(bus_if.write), 64'd1);
    chk("missed_addr", 64'(bus_if.address), 64'd4);
    step();
    bus_if.waitrequest = 1'b0;
    wait_frame_done(6);
    step(); step(); step();
    @(negedge clk);
    chk("missed_idle_busy", 64'(busy), 64'd0);
    chk("missed_hold", 64'(missed_frames), 64'd255);
    step();

    // Reset in the middle of a stalled write.
    upd(S_CAC_X, 32'd66);
    upd(S_CAC_Y, 32'd77);
    bus_if.waitrequest = 1'b1;
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    @(negedge clk);
    chk("prerst_write", 64'(bus_if.write), 64'd1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_write", 64'(bus_if.write), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_missed", 64'(missed_frames), 64'd0);
    step();
    reset = 1'b0;
    bus_if.waitrequest = 1'b0;
    upd(13, 32'd999);
    upd(15, 32'd123);
    frame_log(4);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("postrst_write_c%0d", c), 64'(lg_wr[c]), 64'd0);
    end
    chk("postrst_fd_c1", 64'(lg_fd[1]), 64'd1);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
